id_exe_skid_buffer: RTL and testbench

- Parametrised, elastic successor to the fixed ID→EXE pipeline register.
- Carries the decoded-instruction payload: branch PC, two register values, rs/rt/rd, load-byte constant and sign-extended constant.
- Adds a valid/ready handshake with a 2-entry skid, so ID can stall on EXE back-pressure at full throughput.
- Adds a synchronous flush that squashes wrong-path instructions on a taken branch.

---
 rtl/id_exe_skid_buffer_pkg.sv | 37 +++
 rtl/id_exe_skid_buffer_if.sv | 45 ++++
 rtl/id_exe_skid_buffer_pipe_skid_reg.sv | 80 ++++++++
 rtl/id_exe_skid_buffer.sv | 68 ++++++
 tb/tb_id_exe_skid_buffer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/id_exe_skid_buffer_pkg.sv
// Shared widths, payload layout and skid-state encoding for the ID->EXE elastic stage.
// The same state type is reused by the EXE->MEM and MEM->WB instances of pipe_skid_reg.
package id_exe_pkg;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 3;
    localparam int PC_W    = 6;
    localparam int LB_W    = 8;

    typedef struct packed {
        logic [PC_W-1:0]    bra_pc;
        logic [DATA_W-1:0]  reg1_val;
        logic [DATA_W-1:0]  reg2_val;
        logic [RADDR_W-1:0] rs;
        logic [RADDR_W-1:0] rt;
        logic [RADDR_W-1:0] rd;
        logic [LB_W-1:0]    lb_const;
        logic [DATA_W-1:0]  se_const;
    } id_exe_payload_t;

    localparam int PAYLOAD_W = $bits(id_exe_payload_t);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    function automatic logic [1:0] occ_of(skid_state_e s);
        case (s)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/id_exe_skid_buffer_if.sv
// Valid/ready handshake plus decoded-instruction payload between ID and EXE.
// slave = the buffer's view, master = the ID/EXE environment driving it.
interface id_exe_skid_buffer_if #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3,
    parameter int PC_W    = 6,
    parameter int LB_W    = 8
);
    logic               id_valid;
    logic               id_ready;
    logic [PC_W-1:0]    id_bra_pc;
    logic [DATA_W-1:0]  id_reg1_val;
    logic [DATA_W-1:0]  id_reg2_val;
    logic [RADDR_W-1:0] id_rs;
    logic [RADDR_W-1:0] id_rt;
    logic [RADDR_W-1:0] id_rd;
    logic [LB_W-1:0]    id_lb_const;
    logic [DATA_W-1:0]  id_se_const;

    logic               exe_valid;
    logic               exe_ready;
    logic [PC_W-1:0]    exe_bra_pc;
    logic [DATA_W-1:0]  exe_reg1_val;
    logic [DATA_W-1:0]  exe_reg2_val;
    logic [RADDR_W-1:0] exe_rs;
    logic [RADDR_W-1:0] exe_rt;
    logic [RADDR_W-1:0] exe_rd;
    logic [LB_W-1:0]    exe_lb_const;
    logic [DATA_W-1:0]  exe_se_const;

    modport slave (
        input  id_valid, id_bra_pc, id_reg1_val, id_reg2_val, id_rs, id_rt, id_rd,
               id_lb_const, id_se_const, exe_ready,
        output id_ready, exe_valid, exe_bra_pc, exe_reg1_val, exe_reg2_val, exe_rs,
               exe_rt, exe_rd, exe_lb_const, exe_se_const
    );

    modport master (
        output id_valid, id_bra_pc, id_reg1_val, id_reg2_val, id_rs, id_rt, id_rd,
               id_lb_const, id_se_const, exe_ready,
        input  id_ready, exe_valid, exe_bra_pc, exe_reg1_val, exe_reg2_val, exe_rs,
               exe_rt, exe_rd, exe_lb_const, exe_se_const
    );

endinterface

// File: rtl/id_exe_skid_buffer_pipe_skid_reg.sv
// Generic 2-entry skid register: main entry feeds the output, skid entry absorbs one
// beat of back-pressure so in_ready_o depends on registered state only.
//
// state | meaning
// EMPTY | nothing held, output reads all zeros
// ONE   | main entry valid
// FULL  | main and skid entries valid, input stalled
module pipe_skid_reg
    import id_exe_pkg::*;
#(
    parameter int W = PAYLOAD_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   occupancy_o
);

    skid_state_e  state_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         drain;

    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;
    assign occupancy_o = occ_of(state_q);

    assign accept = in_valid_i & in_ready_o;
    assign drain  = out_valid_o & out_ready_i;

    // Main is zeroed whenever it empties so the consumer sees NOP fields on bubbles.
    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= in_data_i;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_q <= in_data_i;
                    end else if (accept) begin
                        skid_q  <= in_data_i;
                        state_q <= FULL;
                    end else if (drain) begin
                        main_q  <= '0;
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        main_q  <= skid_q;
                        skid_q  <= '0;
                        state_q <= ONE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/id_exe_skid_buffer.sv
// Elastic ID->EXE pipeline register: packs the decoded-instruction fields into one
// payload word and hands it to pipe_skid_reg, with flush squashing wrong-path work.
module id_exe_skid_buffer
    import id_exe_pkg::*;
#(
    parameter int DATA_W  = id_exe_pkg::DATA_W,
    parameter int RADDR_W = id_exe_pkg::RADDR_W,
    parameter int PC_W    = id_exe_pkg::PC_W,
    parameter int LB_W    = id_exe_pkg::LB_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    id_exe_skid_buffer_if.slave  bus,
    output logic [1:0]           occupancy
);

    // Local layout follows the module parameters so non-default widths still pack exactly.
    typedef struct packed {
        logic [PC_W-1:0]    bra_pc;
        logic [DATA_W-1:0]  reg1_val;
        logic [DATA_W-1:0]  reg2_val;
        logic [RADDR_W-1:0] rs;
        logic [RADDR_W-1:0] rt;
        logic [RADDR_W-1:0] rd;
        logic [LB_W-1:0]    lb_const;
        logic [DATA_W-1:0]  se_const;
    } payload_t;

    localparam int PW = $bits(payload_t);

    payload_t in_pl;
    payload_t out_pl;

    assign in_pl.bra_pc   = bus.id_bra_pc;
    assign in_pl.reg1_val = bus.id_reg1_val;
    assign in_pl.reg2_val = bus.id_reg2_val;
    assign in_pl.rs       = bus.id_rs;
    assign in_pl.rt       = bus.id_rt;
    assign in_pl.rd       = bus.id_rd;
    assign in_pl.lb_const = bus.id_lb_const;
    assign in_pl.se_const = bus.id_se_const;

    pipe_skid_reg #(
        .W (PW)
    ) u_skid (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (flush),
        .in_valid_i  (bus.id_valid),
        .in_ready_o  (bus.id_ready),
        .in_data_i   (in_pl),
        .out_valid_o (bus.exe_valid),
        .out_ready_i (bus.exe_ready),
        .out_data_o  (out_pl),
        .occupancy_o (occupancy)
    );

    assign bus.exe_bra_pc   = out_pl.bra_pc;
    assign bus.exe_reg1_val = out_pl.reg1_val;
    assign bus.exe_reg2_val = out_pl.reg2_val;
    assign bus.exe_rs       = out_pl.rs;
    assign bus.exe_rt       = out_pl.rt;
    assign bus.exe_rd       = out_pl.rd;
    assign bus.exe_lb_const = out_pl.lb_const;
    assign bus.exe_se_const = out_pl.se_const;

endmodule

// File: tb/tb_id_exe_skid_buffer.sv
// Directed and randomized checks of id_exe_skid_buffer against a queue-based
// model of a 2-deep FIFO with flush.
module tb_id_exe_skid_buffer;

    localparam int PW = 71;

    logic clock;
    logic reset;
    logic flush;
    logic [1:0] occupancy;

    int checks   = 0;
    int failures = 0;

    logic [PW-1:0] mq[$];

    id_exe_skid_buffer_if bus ();

    id_exe_skid_buffer dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus.slave),
        .occupancy (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [PW-1:0] mk(logic [5:0] pc, logic [15:0] r1, logic [15:0] r2,
                                         logic [2:0] rs, logic [2:0] rt, logic [2:0] rd,
                                         logic [7:0] lb, logic [15:0] se);
        return {pc, r1, r2, rs, rt, rd, lb, se};
    endfunction

    function automatic logic [PW-1:0] exe_pl();
        return {bus.exe_bra_pc, bus.exe_reg1_val, bus.exe_reg2_val, bus.exe_rs, bus.exe_rt,
                bus.exe_rd, bus.exe_lb_const, bus.exe_se_const};
    endfunction

    function automatic logic [PW-1:0] id_pl();
        return {bus.id_bra_pc, bus.id_reg1_val, bus.id_reg2_val, bus.id_rs, bus.id_rt,
                bus.id_rd, bus.id_lb_const, bus.id_se_const};
    endfunction

    function automatic logic [PW-1:0] rnd_pl();
        return PW'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic drive(input logic v, input logic [PW-1:0] pl);
        bus.id_valid = v;
        {bus.id_bra_pc, bus.id_reg1_val, bus.id_reg2_val, bus.id_rs, bus.id_rt,
         bus.id_rd, bus.id_lb_const, bus.id_se_const} = pl;
    endtask

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: at most two held items, ready means fewer than two, head is what EXE sees.
    task automatic cyc();
        bit do_acc;
        bit do_drn;
        logic [PW-1:0] exp_pl;
        if (reset || flush) begin
            mq.delete();
        end else begin
            do_acc = bus.id_valid && (mq.size() < 2);
            do_drn = (mq.size() > 0) && bus.exe_ready;
            if (do_drn) void'(mq.pop_front());
            if (do_acc) mq.push_back(id_pl());
        end
        @(posedge clock);
        #1;
        exp_pl = (mq.size() > 0) ? mq[0] : '0;
        chk("exe_valid", PW'(bus.exe_valid), PW'(mq.size() > 0));
        chk("id_ready", PW'(bus.id_ready), PW'(mq.size() < 2));
        chk("occupancy", PW'(occupancy), PW'(mq.size()));
        chk("payload", exe_pl(), exp_pl);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.exe_ready = 1'b0;
        drive(1'b1, rnd_pl());

        // Reset held two cycles while ID offers an instruction.
        cyc();
        cyc();
        chk("rst_valid", PW'(bus.exe_valid), PW'(0));
        chk("rst_occ", PW'(occupancy), PW'(0));
        chk("rst_ready", PW'(bus.id_ready), PW'(1));
        chk("rst_payload", exe_pl(), PW'(0));

        // Streaming at full rate.
        reset = 1'b0;
        bus.exe_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, mk(6'h0, 16'(i * 16'h0011), 16'h0, 3'(i), 3'h0, 3'h0, 8'h0, 16'h0));
            cyc();
            chk("stream_rs", PW'(bus.exe_rs), PW'(i));
            chk("stream_reg1", PW'(bus.exe_reg1_val), PW'(i * 16'h0011));
            chk("stream_ready", PW'(bus.id_ready), PW'(1));
        end
        drive(1'b0, '0);
        cyc();
        chk("stream_end_valid", PW'(bus.exe_valid), PW'(0));

        // Back-pressure fills the skid; third item is refused.
        bus.exe_ready = 1'b0;
        drive(1'b1, mk(6'h0, 16'h0, 16'h0, 3'd4, 3'h0, 3'h0, 8'h0, 16'h0));
        cyc();
        drive(1'b1, mk(6'h0, 16'h0, 16'h0, 3'd5, 3'h0, 3'h0, 8'h0, 16'h0));
        cyc();
        chk("bp_occ", PW'(occupancy), PW'(2));
        chk("bp_ready", PW'(bus.id_ready), PW'(0));
        chk("bp_rs", PW'(bus.exe_rs), PW'(4));
        drive(1'b1, mk(6'h0, 16'h0, 16'h0, 3'd6, 3'h0, 3'h0, 8'h0, 16'h0));
        cyc();
        chk("bp_hold_rs", PW'(bus.exe_rs), PW'(4));
        chk("bp_hold_occ", PW'(occupancy), PW'(2));
        bus.exe_ready = 1'b1;
        cyc();
        chk("bp_out5", PW'(bus.exe_rs), PW'(5));
        cyc();
        chk("bp_out6", PW'(bus.exe_rs), PW'(6));
        drive(1'b0, '0);
        cyc();
        chk("bp_empty", PW'(bus.exe_valid), PW'(0));

        // Flush while full, with an instruction offered the same cycle.
        bus.exe_ready = 1'b0;
        drive(1'b1, mk(6'h0, 16'h0, 16'h0, 3'h0, 3'h0, 3'h0, 8'h0, 16'hFFFE));
        cyc();
        drive(1'b1, mk(6'h0, 16'h0, 16'h0, 3'h0, 3'h0, 3'h0, 8'h0, 16'h0003));
        cyc();
        chk("fl_full", PW'(occupancy), PW'(2));
        chk("fl_head_se", PW'(bus.exe_se_const), PW'(16'hFFFE));
        flush = 1'b1;
        bus.exe_ready = 1'b1;
        drive(1'b1, mk(6'h3F, 16'h1234, 16'h0, 3'h0, 3'h0, 3'h0, 8'h0, 16'h7777));
        cyc();
        chk("fl_valid", PW'(bus.exe_valid), PW'(0));
        chk("fl_occ", PW'(occupancy), PW'(0));
        chk("fl_se", PW'(bus.exe_se_const), PW'(0));
        flush = 1'b0;
        drive(1'b0, '0);
        cyc();
        chk("fl_lost", PW'(bus.exe_valid), PW'(0));

        // Simultaneous accept and drain in ONE.
        bus.exe_ready = 1'b0;
        drive(1'b1, mk(6'h0A, 16'h0, 16'h0, 3'h0, 3'h0, 3'h0, 8'h0, 16'h0));
        cyc();
        chk("ad_pc_a", PW'(bus.exe_bra_pc), PW'(6'h0A));
        bus.exe_ready = 1'b1;
        drive(1'b1, mk(6'h0B, 16'h0, 16'h0, 3'h0, 3'h0, 3'h0, 8'h0, 16'h0));
        cyc();
        chk("ad_pc_b", PW'(bus.exe_bra_pc), PW'(6'h0B));
        chk("ad_occ", PW'(occupancy), PW'(1));
        drive(1'b0, '0);
        cyc();

        // Single item drained to empty leaves zeroed fields.
        bus.exe_ready = 1'b0;
        drive(1'b1, mk(6'h0, 16'h0, 16'h0, 3'h0, 3'h0, 3'h0, 8'hA5, 16'h0));
        cyc();
        chk("de_lb", PW'(bus.exe_lb_const), PW'(8'hA5));
        drive(1'b0, '0);
        bus.exe_ready = 1'b1;
        cyc();
        chk("de_valid", PW'(bus.exe_valid), PW'(0));
        chk("de_lb_zero", PW'(bus.exe_lb_const), PW'(0));

        // Randomized traffic with occasional flush and mid-stream reset.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 19) == 0);
            bus.exe_ready = ($urandom_range(0, 2) != 0);
            drive(($urandom_range(0, 3) != 0), rnd_pl());
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
